cpu_sequencer: RTL and testbench

//   Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.

---
 rtl/cpu_sequencer_pkg.sv | 55 +++++
 rtl/cpu_sequencer_if.sv | 23 ++
 rtl/cpu_sequencer_instr_decode.sv | 56 +++++
 rtl/cpu_sequencer.sv | 142 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
// Opcode map, FSM state encoding and the decoded-instruction bundle.
package cpu_sequencer_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_NAD = 4'h3;
    localparam logic [3:0] OP_SHR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU strobe vector order: {nad, shr, shl, read}
    localparam logic [3:0] CTL_NAD  = 4'b1000;
    localparam logic [3:0] CTL_SHR  = 4'b0100;
    localparam logic [3:0] CTL_SHL  = 4'b0010;
    localparam logic [3:0] CTL_READ = 4'b0001;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_OPRD,
        S_EXEC,
        S_WR,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_LDA,
        CL_STA,
        CL_ALU,
        CL_JMP,
        CL_JZ,
        CL_LDI,
        CL_HLT
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic       need_opnd;
        logic       is_store;
        logic       is_halt;
        logic       illegal;
        logic [3:0] ctl;
    } dec_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Word-addressed req/ready memory port between the sequencer and memory.
// Request side holds addr/we/wdata stable until ready is seen.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/cpu_sequencer_instr_decode.sv
// Combinational opcode decoder: class, operand/store/halt flags and
// the one-hot ALU strobe vector used while executing or storing.
module cpu_sequencer_instr_decode
    import cpu_sequencer_pkg::*;
(
    input  logic [3:0] op_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o.cls       = CL_NOP;
        dec_o.need_opnd = 1'b0;
        dec_o.is_store  = 1'b0;
        dec_o.is_halt   = 1'b0;
        dec_o.illegal   = 1'b0;
        dec_o.ctl       = '0;
        unique case (op_i)
            OP_NOP: ;
            OP_LDA: begin
                dec_o.cls       = CL_LDA;
                dec_o.need_opnd = 1'b1;
            end
            OP_STA: begin
                dec_o.cls      = CL_STA;
                dec_o.is_store = 1'b1;
                dec_o.ctl      = CTL_READ;
            end
            OP_NAD: begin
                dec_o.cls       = CL_ALU;
                dec_o.need_opnd = 1'b1;
                dec_o.ctl       = CTL_NAD;
            end
            OP_SHR: begin
                dec_o.cls = CL_ALU;
                dec_o.ctl = CTL_SHR;
            end
            OP_SHL: begin
                dec_o.cls = CL_ALU;
                dec_o.ctl = CTL_SHL;
            end
            OP_JMP: dec_o.cls = CL_JMP;
            OP_JZ:  dec_o.cls = CL_JZ;
            OP_LDI: dec_o.cls = CL_LDI;
            OP_HLT: begin
                dec_o.cls     = CL_HLT;
                dec_o.is_halt = 1'b1;
            end
            default: begin
                dec_o.cls     = CL_HLT;
                dec_o.is_halt = 1'b1;
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Owns PC/IR/OPND/ACC, drives the sibling ALU and the memory port.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_sequencer_if.master   mem,
    output logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] arg_data,
    output logic              ctl_nad,
    output logic              ctl_shr,
    output logic              ctl_shl,
    output logic              ctl_read,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_is_zero,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q;
    logic [DATA_W-1:0] ir_q, opnd_q, acc_q;
    logic              req_q, we_q, halted_q, illegal_q;
    logic [3:0]        ctl_q;
    logic [ADDR_W-1:0] ir_addr;
    dec_t              dec;

    assign ir_addr = ir_q[ADDR_W-1:0];

    cpu_sequencer_instr_decode u_instr_decode (
        .op_i  (ir_q[DATA_W-1 -: 4]),
        .dec_o (dec)
    );

    // Branch target resolved in EXEC; also the next fetch address.
    always_comb begin
        pc_d = pc_q;
        if (dec.cls == CL_JMP || (dec.cls == CL_JZ && alu_is_zero))
            pc_d = ir_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            ctl_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_RST: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    we_q    <= 1'b0;
                    addr_q  <= pc_q;
                end
                S_FETCH: if (mem.ready) begin
                    ir_q    <= mem.rdata;
                    pc_q    <= pc_q + ADDR_W'(1);
                    req_q   <= 1'b0;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec.is_halt) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= dec.illegal;
                    end else if (dec.need_opnd) begin
                        state_q <= S_OPRD;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= ir_addr;
                    end else if (dec.is_store) begin
                        state_q <= S_WR;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ir_addr;
                        ctl_q   <= dec.ctl;
                    end else begin
                        state_q <= S_EXEC;
                        ctl_q   <= dec.ctl;
                    end
                end
                S_OPRD: if (mem.ready) begin
                    opnd_q  <= mem.rdata;
                    req_q   <= 1'b0;
                    ctl_q   <= dec.ctl;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    unique case (dec.cls)
                        CL_ALU:  acc_q <= alu_result;
                        CL_LDA:  acc_q <= opnd_q;
                        CL_LDI:  acc_q <= arg_data;
                        default: ;
                    endcase
                    pc_q    <= pc_d;
                    ctl_q   <= '0;
                    req_q   <= 1'b1;
                    we_q    <= 1'b0;
                    addr_q  <= pc_d;
                    state_q <= S_FETCH;
                end
                S_WR: if (mem.ready) begin
                    ctl_q   <= '0;
                    we_q    <= 1'b0;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= S_FETCH;
                end
                S_HALT: ;
                default: state_q <= S_RST;
            endcase
        end
    end

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = we_q ? alu_result : '0;

    assign acc_data = acc_q;
    assign mem_data = opnd_q;
    assign arg_data = {{(DATA_W-ADDR_W){1'b0}}, ir_addr};

    assign {ctl_nad, ctl_shr, ctl_shl, ctl_read} = ctl_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory + ALU models around the DUT,
// memory transfers checked against a queue of expected transactions.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    logic [15:0] acc_data, mem_data, arg_data, alu_result;
    logic ctl_nad, ctl_shr, ctl_shl, ctl_read;
    logic alu_is_zero, halted, illegal;

    cpu_sequencer #(
        .ADDR_W   (12),
        .DATA_W   (16),
        .RESET_PC (12'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (bus),
        .acc_data    (acc_data),
        .mem_data    (mem_data),
        .arg_data    (arg_data),
        .ctl_nad     (ctl_nad),
        .ctl_shr     (ctl_shr),
        .ctl_shl     (ctl_shl),
        .ctl_read    (ctl_read),
        .alu_result  (alu_result),
        .alu_is_zero (alu_is_zero),
        .halted      (halted),
        .illegal     (illegal)
    );

    always_comb begin
        alu_result = acc_data;
        if (ctl_nad)      alu_result = ~(acc_data & mem_data);
        else if (ctl_shr) alu_result = acc_data >> 1;
        else if (ctl_shl) alu_result = acc_data << 1;
    end
    assign alu_is_zero = (acc_data == 16'h0000);

    logic [15:0] mem [0:4095];
    int wait_cfg = 0;
    int wcnt = 0;

    assign bus.ready = bus.req && (wcnt >= wait_cfg);
    assign bus.rdata = mem[bus.addr];

    always @(posedge clk) begin
        if (!bus.req || bus.ready) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (bus.req && bus.we && bus.ready) mem[bus.addr] = bus.wdata;
    end

    int total = 0;
    int bad = 0;
    int nad_cnt = 0;
    int we_cnt = 0;
    int req_cnt = 0;
    logic [28:0] sbq[$];
    logic        prev_wait = 1'b0;
    logic [28:0] prev_x = '0;

    function automatic logic [28:0] xf(logic we, logic [11:0] a, logic [15:0] d);
        return {we, a, (we ? d : 16'h0000)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [28:0] cur, e;
        cur = xf(bus.we, bus.addr, bus.wdata);
        if (rst_n) begin
            chk("ctl_onehot0", 32'($onehot0({ctl_nad, ctl_shr, ctl_shl, ctl_read})), 32'd1);
            if (ctl_nad) nad_cnt++;
            if (bus.req && bus.we) we_cnt++;
            if (bus.req) req_cnt++;
            if (prev_wait && bus.req) chk("hold_stable", 32'(cur), 32'(prev_x));
            if (bus.req && bus.ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("xfer", 32'(cur), 32'(e));
            end
            prev_wait = bus.req && !bus.ready;
            prev_x    = cur;
        end else begin
            prev_wait = 1'b0;
        end
    end

    task automatic restart();
        rst_n = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        nad_cnt = 0;
        we_cnt  = 0;
        req_cnt = 0;
    endtask

    task automatic go();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 300 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int found;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_acc", 32'(acc_data), 32'd0);
        chk("rst_regs", {mem_data, arg_data}, 32'd0);
        chk("rst_outs", {halted, illegal, ctl_nad, ctl_shr, ctl_shl, ctl_read,
                         bus.we, bus.addr, 13'd0}, 32'd0);

        // LDI 0x0AB, then HLT
        mem[0] = 16'h80AB;
        mem[1] = 16'hF000;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        go();
        @(negedge clk);
        chk("t1_req", 32'(bus.req), 32'd1);
        chk("t1_addr", 32'(bus.addr), 32'h000);
        repeat (2) @(negedge clk);
        chk("t1_acc_early", 32'(acc_data), 32'd0);
        @(negedge clk);
        chk("t1_acc", 32'(acc_data), 32'h00AB);
        drain("t1_pc1");

        // LDI 0x0F0; NAD 0x010
        restart();
        mem[0] = 16'h80F0;
        mem[1] = 16'h3010;
        mem[2] = 16'hF000;
        mem[12'h010] = 16'h00FF;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        sbq.push_back(xf(0, 12'h010, 0));
        sbq.push_back(xf(0, 12'h002, 0));
        go();
        drain("t2_xfers");
        chk("t2_acc", 32'(acc_data), 32'hFF0F);
        chk("t2_nad_cycles", 32'(nad_cnt), 32'd1);

        // LDI 1; SHR; JZ 0x020 -> taken
        restart();
        mem[0] = 16'h8001;
        mem[1] = 16'h4000;
        mem[2] = 16'h7020;
        mem[12'h020] = 16'hF000;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        sbq.push_back(xf(0, 12'h002, 0));
        sbq.push_back(xf(0, 12'h020, 0));
        go();
        drain("t3_jz_taken");
        chk("t3_acc0", 32'(acc_data), 32'h0000);

        // LDI 2; SHR; JZ 0x020 -> falls through
        restart();
        mem[0] = 16'h8002;
        mem[3] = 16'hF000;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        sbq.push_back(xf(0, 12'h002, 0));
        sbq.push_back(xf(0, 12'h003, 0));
        go();
        drain("t3_jz_fall");
        chk("t3_acc1", 32'(acc_data), 32'h0001);

        // LDA 0x040 (0x1234); STA 0x030 with 3 wait cycles per transfer
        restart();
        wait_cfg = 3;
        mem[0] = 16'h1040;
        mem[1] = 16'h2030;
        mem[2] = 16'hF000;
        mem[12'h040] = 16'h1234;
        mem[12'h030] = 16'h0000;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h040, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        sbq.push_back(xf(1, 12'h030, 16'h1234));
        sbq.push_back(xf(0, 12'h002, 0));
        go();
        drain("t4_xfers");
        chk("t4_we_cycles", 32'(we_cnt), 32'd4);
        chk("t4_mem30", 32'(mem[12'h030]), 32'h1234);
        wait_cfg = 0;

        // NOPs then illegal opcode 0xA at PC=5
        restart();
        for (int i = 0; i < 5; i++) mem[i] = 16'h0000;
        mem[5] = 16'hA000;
        for (int i = 0; i < 6; i++) sbq.push_back(xf(0, 12'(i), 0));
        go();
        drain("t5_fetches");
        repeat (3) @(negedge clk);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_illegal", 32'(illegal), 32'd1);
        req_cnt = 0;
        repeat (10) @(negedge clk);
        chk("t5_no_req", 32'(req_cnt), 32'd0);

        // HLT
        restart();
        mem[0] = 16'hF000;
        sbq.push_back(xf(0, 12'h000, 0));
        go();
        drain("t5_hlt_fetch");
        repeat (3) @(negedge clk);
        chk("t5_hlt_halted", 32'(halted), 32'd1);
        chk("t5_hlt_illegal", 32'(illegal), 32'd0);

        // reset while an operand read is stalled
        restart();
        wait_cfg = 5;
        mem[0] = 16'h8055;
        mem[1] = 16'h1050;
        mem[12'h050] = 16'h7777;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'h001, 0));
        go();
        drain("t6_pre");
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req && !bus.we && bus.addr == 12'h050) begin
                found = 1;
                break;
            end
        end
        chk("t6_oprd_seen", 32'(found), 32'd1);
        chk("t6_oprd_wait", 32'(bus.ready), 32'd0);
        chk("t6_acc_before", 32'(acc_data), 32'h0055);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_drop", 32'(bus.req), 32'd0);
        chk("t6_acc_clr", 32'(acc_data), 32'd0);
        chk("t6_regs_clr", {mem_data, arg_data}, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        wait_cfg = 0;
        sbq.push_back(xf(0, 12'h000, 0));
        go();
        drain("t6_refetch");

        // PC wraps from 0xFFF to 0x000
        restart();
        mem[0] = 16'h6FFF;
        mem[12'hFFF] = 16'h0000;
        sbq.push_back(xf(0, 12'h000, 0));
        sbq.push_back(xf(0, 12'hFFF, 0));
        sbq.push_back(xf(0, 12'h000, 0));
        go();
        drain("t6_pc_wrap");

        restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
